wb_spi_master: RTL and testbench
================================

// Module: wb_spi_master
// PURPOSE
//  Wishbone-slave-controlled SPI master: the initiator end of the SPI link whose responder is wb_spi_slave.
//  A Wishbone master (CPU or SPI-bridge) writes bytes into a small register file; block shifts them out
//  mode 0 (CPOL=0, CPHA=0), MSB first, while capturing MISO. Sits on the on-chip Wishbone bus next to
//  other peripherals, drives an external SPI target (sensor, flash, or a second SoM).
// PARAMETERS
//  ADR_W        24  Wishbone address width; only i_wb_adr[1:0] decoded, upper bits ignored (aliased).
//  DEFAULT_DIV  3   Reset value of CTRL.clkdiv; SCK half-period = (clkdiv+1) clk cycles.
// PORTS
//  clk        in   1      System clock (SB_HFOSC domain).
//  rst_n      in   1      Asynchronous active-low reset.
//  i_wb_cyc   in   1      Wishbone cycle.
//  i_wb_stb   in   1      Wishbone strobe.
//  i_wb_we    in   1      1 = write, 0 = read.
//  i_wb_adr   in   ADR_W  Word address.
//  i_wb_dat   in   32     Write data.
//  o_wb_dat   out  32     Read data, registered.
//  o_wb_ack   out  1      Single-cycle acknowledge.
//  o_sck      out  1      SPI clock, idles low.
//  o_ssn      out  1      SPI select, active low, idles high.
//  o_mosi     out  1      SPI data out.
//  i_miso     in   1      SPI data in (treated as synchronous to clk; sampled on SCK rise event).
//  o_busy     out  1      Transfer in progress.
//  o_irq      out  1      Level interrupt = STATUS.rx_valid & CTRL.irq_en.
// BEHAVIOUR
//  Reset (async): o_sck=0, o_ssn=1, o_mosi=0, o_wb_ack=0, o_wb_dat=0, o_busy=0, o_irq=0; CTRL={clkdiv=DEFAULT_DIV,
//   irq_en=0, cs_hold=0}; STATUS=0; RXDATA=0; FSM=IDLE. Reset mid-transfer aborts immediately, no partial RX.
//  Bus: o_wb_ack asserted the cycle after (cyc&stb&!ack), for one cycle; no wait states; read data valid with ack.
//  Registers (word addr[1:0]):
//   0 CTRL   RW [0] cs_hold, [1] irq_en, [15:8] clkdiv; other bits read 0.
//   1 STATUS R  [0] busy, [1] rx_valid, [2] overrun; W1C on bits [2:1].
//   2 TXDATA W  [7:0]; write when idle starts transfer; write when busy ignored and sets overrun. Reads 0.
//   3 RXDATA R  [7:0] last received byte; a read clears rx_valid.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
//   IDLE: on accepted TXDATA write, load shift reg, busy=1 next cycle, o_ssn=0, o_mosi=bit7 -> SETUP.
//   SETUP: wait one half-period -> SHIFT.
//   SHIFT: 16 half-periods; rising edge: sample i_miso into LSB; falling edge: shift, drive next bit.
//    Bit counter 0..7; after 8th rising edge and following falling edge (sck back to 0) -> HOLD.
//   HOLD: one half-period; then RXDATA<=shift reg, rx_valid=1, busy=0; o_ssn=1 unless cs_hold -> IDLE.
//  Transfer length: 18*(clkdiv+1) clk from first busy cycle to busy low. clkdiv=0 legal (SCK=clk/2).
//  clkdiv change while busy takes effect at next half-period boundary (software must not rely on it).
//  cs_hold=1: o_ssn stays low between back-to-back bytes; clearing cs_hold while IDLE raises o_ssn next cycle.
//  Simultaneous events: set wins over clear (rx_valid set vs RXDATA read or W1C same cycle -> stays 1;
//   overrun set vs W1C -> stays 1). Write TXDATA on the cycle FSM returns to IDLE is accepted (not overrun).
//  Half-period counter wraps to 0 at clkdiv; no other counters wrap.
// TESTING
//  T1 reset: assert rst_n=0 mid-stream -> o_ssn=1, o_sck=0, busy=0; read CTRL = 0x0000_0300, STATUS = 0.
//  T2 loopback (mosi->miso), clkdiv=1: write TXDATA=0xA5 -> 8 SCK rises, period 4 clk, busy 36 clk, RXDATA=0xA5, rx_valid=1.
//  T3 overrun: write 0x3C then 0xFF while busy -> MOSI carries 0x3C only, STATUS=0x5 during xfer; W1C 0x4 clears bit2.
//  T4 cs_hold=1: send 0x12, 0x34 back to back -> o_ssn low throughout; clear cs_hold -> o_ssn high next cycle.
//  T5 irq: irq_en=1, send byte -> o_irq rises with rx_valid; read RXDATA -> o_irq low next cycle.
//  T6 clkdiv=0, miso tied 1: write 0x00 -> SCK toggles every clk, RXDATA=0xFF, busy 18 clk.

Source files
------------

// File: rtl/wb_spi_master_if.sv
// wb_spi_master_if: Wishbone slave bus bundle for the SPI master register file
interface wb_spi_master_if #(parameter int ADR_W = 24);
  logic cyc;
  logic stb;
  logic we;
  logic [ADR_W-1:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic ack;
  modport master(output cyc, stb, we, adr, wdat, input rdat, ack);
  modport slave(input cyc, stb, we, adr, wdat, output rdat, ack);
endinterface

// File: rtl/wb_spi_master.sv
// wb_spi_master: Wishbone-controlled SPI mode-0 master, MSB first, one byte per transfer
module wb_spi_master #(
  parameter int ADR_W = 24,
  parameter logic [7:0] DEFAULT_DIV = 8'd3
) (
  input  logic clk,
  input  logic rst_n,
  wb_spi_master_if.slave wb,
  output logic o_sck,
  output logic o_ssn,
  output logic o_mosi,
  input  logic i_miso,
  output logic o_busy,
  output logic o_irq
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_n;
  logic cs_hold, irq_en, rx_valid, overrun;
  logic [7:0] clkdiv, hcnt, shreg, rxdata;
  logic [2:0] bcnt;
  logic req, wr, rd, hdone, done, ready, start, unused;
  logic [1:0] a;
  assign a = wb.adr[1:0];
  assign req = wb.cyc && wb.stb && !wb.ack;
  assign wr = req && wb.we;
  assign rd = req && !wb.we;
  assign hdone = hcnt >= clkdiv;
  assign done = state == HOLD && hdone;
  assign ready = state == IDLE || done;
  assign start = wr && a == 2'd2 && ready;
  assign o_busy = state != IDLE;
  assign o_ssn = state == IDLE && !cs_hold;
  assign o_irq = rx_valid && irq_en;
  assign unused = ^{wb.adr[ADR_W-1:2], wb.wdat[31:16]};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state: each non-idle state advances on a half-period boundary
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? SETUP : IDLE;
      SETUP: state_n = hdone ? SHIFT : SETUP;
      SHIFT: state_n = (hdone && o_sck && bcnt == 3'd7) ? HOLD : SHIFT;
      HOLD:  state_n = start ? SETUP : hdone ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  // shift datapath: sample MISO on SCK rise, present next MOSI bit on SCK fall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt <= 8'd0;
      bcnt <= 3'd0;
      shreg <= 8'd0;
      rxdata <= 8'd0;
      o_sck <= 1'b0;
      o_mosi <= 1'b0;
    end else begin
      if (start) begin
        hcnt <= 8'd0;
        bcnt <= 3'd0;
        shreg <= wb.wdat[7:0];
        o_mosi <= wb.wdat[7];
        o_sck <= 1'b0;
      end else if (state != IDLE) begin
        hcnt <= hdone ? 8'd0 : hcnt + 8'd1;
        if (state == SHIFT && hdone && !o_sck) begin
          o_sck <= 1'b1;
          shreg <= {shreg[6:0], i_miso};
        end
        if (state == SHIFT && hdone && o_sck) begin
          o_sck <= 1'b0;
          o_mosi <= shreg[7];
          bcnt <= bcnt + {2'b0, bcnt != 3'd7};
        end
      end
      if (done) rxdata <= shreg;
    end
  // register file and bus response; status sets take priority over clears
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb.ack <= 1'b0;
      wb.rdat <= 32'd0;
      clkdiv <= DEFAULT_DIV;
      irq_en <= 1'b0;
      cs_hold <= 1'b0;
      rx_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      wb.ack <= req;
      if (rd)
        wb.rdat <= a == 2'd0 ? {16'd0, clkdiv, 6'd0, irq_en, cs_hold} :
                   a == 2'd1 ? {29'd0, overrun, rx_valid, o_busy} :
                   a == 2'd3 ? {24'd0, rxdata} : 32'd0;
      if (wr && a == 2'd0) begin
        clkdiv <= wb.wdat[15:8];
        irq_en <= wb.wdat[1];
        cs_hold <= wb.wdat[0];
      end
      rx_valid <= done || (rx_valid && !(rd && a == 2'd3) && !(wr && a == 2'd1 && wb.wdat[1]));
      overrun <= (wr && a == 2'd2 && !ready) || (overrun && !(wr && a == 2'd1 && wb.wdat[2]));
    end
endmodule

// File: tb/tb_wb_spi_master.sv
// tb_wb_spi_master: directed tests with a transfer-level reference model checked every cycle
module tb_wb_spi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_spi_master_if #(.ADR_W(24)) wb();
  logic sck, ssn, mosi, miso, busy, irq;
  logic miso_one = 1'b0;
  assign miso = miso_one ? 1'b1 : mosi;
  wb_spi_master #(.ADR_W(24), .DEFAULT_DIV(8'd3)) dut (
    .clk(clk), .rst_n(rst_n), .wb(wb), .o_sck(sck), .o_ssn(ssn),
    .o_mosi(mosi), .i_miso(miso), .o_busy(busy), .o_irq(irq)
  );
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: a transfer is 18 half-periods counted from the first busy cycle
  int m_k;
  bit m_ack, m_cs, m_ie, m_rv, m_ov;
  logic [7:0] m_div, m_hd, m_tx, m_rx, m_rxb;
  logic [31:0] m_rdat;
  logic m_req, m_end;
  logic [1:0] wa;
  assign wa = wb.adr[1:0];
  assign m_req = wb.cyc && wb.stb && !m_ack;
  assign m_end = m_k != 0 && m_k == 18 * (m_hd + 1);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_k <= 0; m_ack <= 0; m_cs <= 0; m_ie <= 0; m_rv <= 0; m_ov <= 0;
      m_div <= 8'd3; m_hd <= 8'd3; m_tx <= 0; m_rx <= 0; m_rxb <= 0; m_rdat <= 0;
    end else begin
      m_ack <= m_req;
      if (m_req && !wb.we)
        m_rdat <= wa == 0 ? {16'd0, m_div, 6'd0, m_ie, m_cs} :
                  wa == 1 ? {29'd0, m_ov, m_rv, m_k > 0} :
                  wa == 3 ? {24'd0, m_rx} : 32'd0;
      if (m_end) begin m_k <= 0; m_rx <= m_rxb; end
      else if (m_k > 0) m_k <= m_k + 1;
      if (m_req && wb.we && wa == 2) begin
        if (m_k == 0 || m_end) begin
          m_k <= 1; m_tx <= wb.wdat[7:0]; m_hd <= m_div;
          m_rxb <= miso_one ? 8'hFF : wb.wdat[7:0];
        end
      end
      if (m_req && wb.we && wa == 0) begin
        m_div <= wb.wdat[15:8]; m_ie <= wb.wdat[1]; m_cs <= wb.wdat[0];
      end
      m_rv <= m_end || (m_rv && !(m_req && !wb.we && wa == 3) && !(m_req && wb.we && wa == 1 && wb.wdat[1]));
      m_ov <= (m_req && wb.we && wa == 2 && m_k != 0 && !m_end) ||
              (m_ov && !(m_req && wb.we && wa == 1 && wb.wdat[2]));
    end
  // per-cycle comparison against the model
  always @(negedge clk)
    if (rst_n) begin
      chk("ack", wb.ack, m_ack);
      if (m_ack) chk("rdat", wb.rdat, m_rdat);
      chk("busy", busy, m_k > 0);
      chk("ssn", ssn, m_k > 0 ? 1'b0 : !m_cs);
      chk("irq", irq, m_rv && m_ie);
      if (m_k > 0) begin
        int h;
        h = (m_k - 1) / (m_hd + 1);
        chk("sck", sck, h >= 2 && h <= 16 && h % 2 == 0);
        if (h <= 16) chk("mosi", mosi, m_tx[h == 0 ? 7 : 7 - (h - 1) / 2]);
      end else chk("sck_idle", sck, 1'b0);
    end
  int rises = 0;
  logic [7:0] mcap = 0;
  always @(posedge sck) begin rises++; mcap = {mcap[6:0], mosi}; end
  bit watch = 0;
  int ssn_hi = 0;
  always @(negedge clk) if (watch && ssn) ssn_hi++;
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wb.cyc = 1; wb.stb = 1; wb.we = 1; wb.adr = {22'd0, a}; wb.wdat = d;
    @(negedge clk);
    wb.cyc = 0; wb.stb = 0; wb.we = 0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    wb.cyc = 1; wb.stb = 1; wb.we = 0; wb.adr = {22'd0, a};
    @(negedge clk);
    d = wb.rdat;
    wb.cyc = 0; wb.stb = 0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 2000) begin n++; @(negedge clk); end
  endtask
  task automatic xfer(input logic [7:0] b, output int n);
    rises = 0; mcap = 0;
    wr(2'd2, {24'd0, b});
    wait_idle(n);
  endtask
  logic [31:0] d;
  int n;
  initial begin
    wb.cyc = 0; wb.stb = 0; wb.we = 0; wb.adr = 0; wb.wdat = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    rd(2'd0, d); chk("t1_ctrl_reset", d, 32'h0000_0300);
    rd(2'd1, d); chk("t1_status_reset", d, 32'h0);
    wr(2'd2, 32'h81);
    repeat (30) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t1_ssn", ssn, 1'b1); chk("t1_sck", sck, 1'b0); chk("t1_busy", busy, 1'b0);
    @(negedge clk); rst_n = 1;
    rd(2'd0, d); chk("t1_ctrl", d, 32'h0000_0300);
    rd(2'd1, d); chk("t1_status", d, 32'h0);
    rd(2'd3, d); chk("t1_rxdata", d, 32'h0);
    wr(2'd0, 32'h100);
    xfer(8'hA5, n);
    chk("t2_busy_len", n, 36); chk("t2_rises", rises, 8); chk("t2_mosi", mcap, 8'hA5);
    rd(2'd1, d); chk("t2_status", d, 32'h2);
    rd(2'd3, d); chk("t2_rxdata", d, 32'hA5);
    rd(2'd1, d); chk("t2_status_clr", d, 32'h0);
    rises = 0; mcap = 0;
    wr(2'd2, 32'h3C);
    wr(2'd2, 32'hFF);
    rd(2'd1, d); chk("t3_status_busy", d, 32'h5);
    wait_idle(n);
    chk("t3_mosi", mcap, 8'h3C);
    rd(2'd1, d); chk("t3_status_done", d, 32'h6);
    wr(2'd1, 32'h4);
    rd(2'd1, d); chk("t3_w1c", d, 32'h2);
    rd(2'd3, d); chk("t3_rxdata", d, 32'h3C);
    wr(2'd0, 32'h101);
    watch = 1; ssn_hi = 0;
    xfer(8'h12, n);
    xfer(8'h34, n);
    watch = 0;
    chk("t4_ssn_low", ssn_hi, 0); chk("t4_mosi", mcap, 8'h34);
    rd(2'd3, d); chk("t4_rxdata", d, 32'h34);
    chk("t4_ssn_before", ssn, 1'b0);
    wr(2'd0, 32'h100);
    chk("t4_ssn_release", ssn, 1'b1);
    wr(2'd0, 32'h102);
    chk("t5_irq_idle", irq, 1'b0);
    xfer(8'h5A, n);
    chk("t5_irq_set", irq, 1'b1);
    rd(2'd3, d); chk("t5_rxdata", d, 32'h5A);
    chk("t5_irq_clr", irq, 1'b0);
    wr(2'd0, 32'h000);
    miso_one = 1;
    xfer(8'h00, n);
    chk("t6_busy_len", n, 18); chk("t6_rises", rises, 8);
    rd(2'd3, d); chk("t6_rxdata", d, 32'hFF);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
